// File: rtl/moore_1010_non_overlap_pkg.sv
// moore_1010_non_overlap_pkg: state width and encoding shared by FSM-style serial detectors
package moore_1010_non_overlap_pkg;
    localparam int STATE_W = 3;
    typedef enum logic [STATE_W-1:0] {
        S0 = 3'b000,
        S1 = 3'b001,
        S2 = 3'b010,
        S3 = 3'b011,
        S4 = 3'b100
    } state_t;
endpackage

// File: rtl/moore_1010_non_overlap.sv
// moore_1010_non_overlap: Moore detector for serial pattern 1010, matches never share bits
module moore_1010_non_overlap
    import moore_1010_non_overlap_pkg::*;
(
    input  logic clk,
    input  logic rst,
    input  logic x,
    output logic z
);
    state_t state_q, state_d;
    always_ff @(posedge clk) begin
        state_q <= rst ? S0 : state_d;
    end
    // unused codes fall back to idle through the default
    always_comb begin
        state_d = S0;
        z = (state_q == S4);
        case (state_q)
            S0: state_d = x ? S1 : S0;
            S1: state_d = x ? S1 : S2;
            S2: state_d = x ? S3 : S0;
            S3: state_d = x ? S1 : S4;
            S4: state_d = x ? S1 : S0;
            default: state_d = S0;
        endcase
    end
endmodule

// File: tb/tb_moore_1010_non_overlap.sv
// tb_moore_1010_non_overlap: directed and random stream checks against a match-buffer model
module tb_moore_1010_non_overlap;
    logic clk = 1'b0;
    logic rst = 1'b1;
    logic x = 1'b0;
    logic z;
    int compared = 0;
    int mismatched = 0;
    int pulses = 0;
    logic [3:0] hist = 4'b0;
    int n = 0;
    logic exp_z = 1'b0;
    logic [2:0] exp_state = 3'b000;

    moore_1010_non_overlap dut (.clk(clk), .rst(rst), .x(x), .z(z));

    always #5 clk = ~clk;

    task automatic check_val(input string tag, input logic [2:0] obs, input logic [2:0] expv);
        compared++;
        assert (obs === expv) else begin
            mismatched++;
            $error("FAIL %s: got %0d expected %0d", tag, obs, expv);
        end
    endtask

    // Model: bits received since the last reset or match; the state is the longest
    // tail of that buffer that begins the pattern 1010, or 4 on a completed match.
    task automatic step(input logic xv, input logic r, input string tag);
        x = xv;
        rst = r;
        @(posedge clk);
        #1;
        if (r) begin
            hist = 4'b0;
            n = 0;
            exp_z = 1'b0;
        end else begin
            hist = {hist[2:0], xv};
            n = (n < 4) ? n + 1 : 4;
            exp_z = (n == 4) && (hist == 4'b1010);
            if (exp_z) n = 0;
        end
        if (exp_z) exp_state = 3'd4;
        else if (n >= 3 && hist[2:0] == 3'b101) exp_state = 3'd3;
        else if (n >= 2 && hist[1:0] == 2'b10) exp_state = 3'd2;
        else if (n >= 1 && hist[0]) exp_state = 3'd1;
        else exp_state = 3'd0;
        if (z === 1'b1) pulses++;
        check_val({tag, " z"}, {2'b0, z}, {2'b0, exp_z});
        check_val({tag, " state"}, dut.state_q, exp_state);
    endtask

    task automatic run_seq(input logic [15:0] bits, input int len, input string tag);
        for (int i = len - 1; i >= 0; i--) step(bits[i], 1'b0, tag);
    endtask

    initial begin
        step(1'b1, 1'b1, "reset0");
        step(1'b0, 1'b1, "reset1");
        for (int i = 0; i < 3; i++) step(1'b0, 1'b0, "idle");
        pulses = 0;
        run_seq(16'b1010, 4, "basic");
        step(1'b0, 1'b0, "basic_after");
        check_val("basic_pulses", pulses[2:0], 3'd1);
        step(1'b1, 1'b1, "rst");
        pulses = 0;
        run_seq(16'b101010, 6, "nonoverlap");
        step(1'b0, 1'b0, "nonoverlap_after");
        check_val("nonoverlap_pulses", pulses[2:0], 3'd1);
        step(1'b0, 1'b1, "rst");
        pulses = 0;
        run_seq(16'b110101011101010, 15, "mixed");
        check_val("mixed_final_state", dut.state_q, 3'b010);
        check_val("mixed_pulses", pulses[2:0], 3'd2);
        step(1'b0, 1'b1, "rst");
        pulses = 0;
        run_seq(16'b1011010, 7, "restart1011");
        check_val("restart1011_pulses", pulses[2:0], 3'd1);
        step(1'b0, 1'b1, "rst");
        pulses = 0;
        run_seq(16'b100, 3, "restart100");
        check_val("restart100_state", dut.state_q, 3'b000);
        run_seq(16'b1010, 4, "restart100_match");
        check_val("restart100_pulses", pulses[2:0], 3'd1);
        step(1'b0, 1'b1, "rst");
        pulses = 0;
        run_seq(16'b101, 3, "midrst_pre");
        step(1'b0, 1'b1, "midrst");
        step(1'b0, 1'b0, "midrst_post");
        check_val("midrst_pulses", pulses[2:0], 3'd0);
        run_seq(16'b1010, 4, "midrst_fresh");
        check_val("midrst_fresh_pulses", pulses[2:0], 3'd1);
        for (int i = 0; i < 400; i++)
            step(1'($urandom_range(0, 1)), ($urandom_range(0, 49) == 0), "random");
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end
endmodule
